// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter and its round-robin picker.
package fifo_wr_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int DEF_BURST_TIMEOUT = 15;

  // Index width for n items; never below 1 so single-bit ports stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any_valid
);

  // Scan from the farthest offset down so the nearest offset to ptr wins.
  always_comb begin
    int j;
    logic [IW-1:0] j_idx;
    j         = 0;
    j_idx     = '0;
    grant     = '0;
    idx       = '0;
    any_valid = |req;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      j_idx = IW'(j);
      if (req[j_idx]) begin
        idx          = j_idx;
        grant        = '0;
        grant[j_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst-locking write arbiter in front of a FIFO write port, zero added latency.
// Optional stalled-burst release: define FIFO_WR_ARB_BURST_TIMEOUT_EN.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int BURST_TIMEOUT = DEF_BURST_TIMEOUT,
  localparam int OW           = clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_wr_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          busy,
  output logic [OW-1:0]                 owner
);

  if (NUM_REQ < 2 || NUM_REQ > 16 || BURST_TIMEOUT < 1) begin : g_bad_cfg
    $error("fifo_wr_arbiter: unsupported parameter set");
  end

  state_e        state_q, state_d;
  logic [OW-1:0] rr_ptr_q, rr_ptr_d;
  logic [OW-1:0] owner_q, owner_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [OW-1:0]      pick_idx;
  logic               pick_any;
  logic [OW-1:0]      winner;
  logic               win_valid;
  logic               win_last;

  // Wrap explicitly so non-power-of-two NUM_REQ returns to 0, not NUM_REQ.
  function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + OW'(1);
  endfunction

  rr_pick #(.N(NUM_REQ), .IW(OW)) u_pick (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  always_comb begin
    winner    = (state_q == BURST) ? owner_q : pick_idx;
    win_valid = (state_q == BURST) ? req_valid[owner_q] : pick_any;
    win_last  = req_last[winner];
  end

  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = req_data[winner*DATA_WIDTH +: DATA_WIDTH];
    if (!reset && fifo_wr_ready) begin
      if (state_q == BURST) req_ready[owner_q] = 1'b1;
      else                  req_ready          = pick_grant;
      fifo_wr_en = win_valid;
    end
  end

`ifdef FIFO_WR_ARB_BURST_TIMEOUT_EN
  localparam int TW = clog2(BURST_TIMEOUT + 1);
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
`ifdef FIFO_WR_ARB_BURST_TIMEOUT_EN
    idle_cnt_d = idle_cnt_q;
`endif
    if (fifo_wr_en) begin
      if (state_q == IDLE) begin
        owner_d = winner;
        if (win_last) rr_ptr_d = next_idx(winner);
        else          state_d  = BURST;
      end else if (win_last) begin
        state_d  = IDLE;
        rr_ptr_d = next_idx(owner_q);
      end
`ifdef FIFO_WR_ARB_BURST_TIMEOUT_EN
      idle_cnt_d = '0;
    end else if (state_q == BURST && !req_valid[owner_q]) begin
      // Owner has gone quiet; after BURST_TIMEOUT such cycles release the lock.
      if (idle_cnt_q == TW'(BURST_TIMEOUT - 1)) begin
        state_d    = IDLE;
        rr_ptr_d   = next_idx(owner_q);
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + TW'(1);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
`ifdef FIFO_WR_ARB_BURST_TIMEOUT_EN
      idle_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
`ifdef FIFO_WR_ARB_BURST_TIMEOUT_EN
      idle_cnt_q <= idle_cnt_d;
`endif
    end
  end

  assign busy  = (state_q == BURST);
  assign owner = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: queue/arithmetic reference model plus directed scenarios.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic          fifo_wr_ready, fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic          busy;
  logic [1:0]    owner;

  logic [DW-1:0] dat [N];

  int checks = 0;
  int errors = 0;

  int            wr_idx[$];
  logic [DW-1:0] wr_dat[$];

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_wr_ready (fifo_wr_ready),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_wr_data  (fifo_wr_data),
    .busy          (busy),
    .owner         (owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: lock flag, round-robin pointer, owner, idle count.
  bit m_init = 0;
  bit m_burst;
  int m_rr, m_owner, m_cnt;

  function automatic int pick(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++)
      if (v[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  function automatic int mwin();
    return m_burst ? m_owner : pick(req_valid, m_rr);
  endfunction

  always @(negedge clk) begin
    int w;
    int exp_rdy, exp_en;
    if (m_init) begin
      w = mwin();
      exp_rdy = 0;
      exp_en  = 0;
      if (!reset && fifo_wr_ready && w >= 0) begin
        exp_rdy = 1 << w;
        exp_en  = int'(req_valid[w]);
      end
      chk("req_ready", int'(req_ready), exp_rdy);
      chk("fifo_wr_en", int'(fifo_wr_en), exp_en);
      chk("busy", int'(busy), int'(m_burst));
      chk("owner", int'(owner), m_owner);
      if (exp_en != 0) begin
        chk("fifo_wr_data", int'(fifo_wr_data), int'(req_data[w*DW +: DW]));
        wr_idx.push_back(w);
        wr_dat.push_back(fifo_wr_data);
      end
    end
  end

  always @(posedge clk) begin
    int w;
    if (reset) begin
      m_burst = 0; m_rr = 0; m_owner = 0; m_cnt = 0; m_init = 1;
    end else if (m_init) begin
      w = mwin();
      if (w >= 0 && fifo_wr_ready && req_valid[w]) begin
        m_cnt = 0;
        if (!m_burst) begin
          m_owner = w;
          if (req_last[w]) m_rr = (w + 1) % N;
          else             m_burst = 1;
        end else if (req_last[w]) begin
          m_burst = 0;
          m_rr    = (m_owner + 1) % N;
        end
      end
`ifdef FIFO_WR_ARB_BURST_TIMEOUT_EN
      else if (m_burst && !req_valid[m_owner]) begin
        m_cnt++;
        if (m_cnt == TO) begin
          m_burst = 0;
          m_rr    = (m_owner + 1) % N;
          m_cnt   = 0;
        end
      end
`endif
    end
  end

  task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] l, input logic rdy, input logic rst);
    @(posedge clk);
    #1;
    req_valid     = v;
    req_last      = l;
    fifo_wr_ready = rdy;
    reset         = rst;
    req_data      = {dat[3], dat[2], dat[1], dat[0]};
    @(negedge clk);
    #1;
  endtask

  initial begin
    int base;
    int e2[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int e3[5] = '{1, 1, 1, 3, 0};
    logic [DW-1:0] e4[3] = '{8'h11, 8'h12, 8'h13};
    int n6;

    dat[0] = 8'h00; dat[1] = 8'h10; dat[2] = 8'h20; dat[3] = 8'h30;
    reset = 1'b1; req_valid = '0; req_last = '0; fifo_wr_ready = 1'b1;
    req_data = '0;

    cyc(4'b0000, 4'b0000, 1'b1, 1'b1);
    cyc(4'b1111, 4'b1111, 1'b1, 1'b1);
    chk("rst_wr_en", int'(fifo_wr_en), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    cyc(4'b0000, 4'b0000, 1'b1, 1'b0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_owner", int'(owner), 0);

    // 1: single requester, same-cycle write
    dat[2] = 8'hA5;
    cyc(4'b0100, 4'b0100, 1'b1, 1'b0);
    chk("t1_wr_en", int'(fifo_wr_en), 1);
    chk("t1_wr_data", int'(fifo_wr_data), 8'hA5);
    chk("t1_req_ready", int'(req_ready), 4'b0100);
    cyc(4'b1111, 4'b1111, 1'b1, 1'b0);
    chk("t1_next_rr", wr_idx[$], 3);

    // 2: fair rotation from reset
    cyc(4'b1111, 4'b1111, 1'b1, 1'b1);
    base = wr_idx.size();
    for (int i = 0; i < 8; i++) cyc(4'b1111, 4'b1111, 1'b1, 1'b0);
    chk("t2_count", wr_idx.size() - base, 8);
    for (int i = 0; i < 8; i++) chk("t2_order", wr_idx[base+i], e2[i]);

    // 3: 3-beat burst from req 1 while 0 and 3 compete
    cyc(4'b0001, 4'b0001, 1'b1, 1'b0);
    base = wr_idx.size();
    cyc(4'b1011, 4'b1001, 1'b1, 1'b0);
    cyc(4'b1011, 4'b1001, 1'b1, 1'b0);
    chk("t3_busy", int'(busy), 1);
    cyc(4'b1011, 4'b1011, 1'b1, 1'b0);
    cyc(4'b1001, 4'b1001, 1'b1, 1'b0);
    cyc(4'b0001, 4'b0001, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) chk("t3_order", wr_idx[base+i], e3[i]);

    // 4: FIFO backpressure mid-burst
    base = wr_idx.size();
    dat[1] = 8'h11;
    cyc(4'b0011, 4'b0001, 1'b1, 1'b0);
    dat[1] = 8'h12;
    for (int i = 0; i < 5; i++) begin
      cyc(4'b0011, 4'b0001, 1'b0, 1'b0);
      chk("t4_stall_en", int'(fifo_wr_en), 0);
      chk("t4_stall_busy", int'(busy), 1);
    end
    cyc(4'b0011, 4'b0001, 1'b1, 1'b0);
    dat[1] = 8'h13;
    cyc(4'b0011, 4'b0011, 1'b1, 1'b0);
    chk("t4_count", wr_idx.size() - base, 3);
    for (int i = 0; i < 3; i++) chk("t4_data", int'(wr_dat[base+i]), int'(e4[i]));

    // 5: reset during a burst owned by req 2
    cyc(4'b0100, 4'b0000, 1'b1, 1'b0);
    chk("t5_owner", wr_idx[$], 2);
    cyc(4'b1111, 4'b0000, 1'b1, 1'b1);
    base = wr_idx.size();
    cyc(4'b1111, 4'b1111, 1'b1, 1'b0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_next", wr_idx[$], 0);
    chk("t5_count", wr_idx.size() - base, 1);

    // 6: owner 1 goes quiet mid-burst with req 2 waiting
    cyc(4'b0010, 4'b0000, 1'b1, 1'b0);
    base = wr_idx.size();
    for (int i = 0; i < 8; i++) begin
      cyc(4'b0100, 4'b0100, 1'b1, 1'b0);
`ifdef FIFO_WR_ARB_BURST_TIMEOUT_EN
      if (i == 3) chk("t6_busy_before", int'(busy), 1);
      if (i == 4) chk("t6_busy_after", int'(busy), 0);
`else
      if (i == 4) chk("t6_busy_locked", int'(busy), 1);
`endif
    end
    n6 = wr_idx.size() - base;
`ifdef FIFO_WR_ARB_BURST_TIMEOUT_EN
    chk("t6_req2_writes", n6, 4);
`else
    chk("t6_req2_writes", n6, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
